sar_adc_ctrl: RTL and testbench
===============================

# sar_adc_ctrl

Successive-approximation controller for the on-chip SAR ADC. It is started by the top-level measurement sequencer's one-cycle start pulse. It drives the track/hold switch and the DAC trial code, and resolves one bit per trial from the comparator. It returns the conversion result together with a one-cycle end-of-conversion pulse that the sequencer waits on before launching transmission.

## Interface
- Width, 8: result/DAC code width in bits (>= 2).
- SampleCycles, 4: cycles `sample_o` is held high (>= 1).
- SettleCycles, 2: DAC settling cycles before each comparator decision (>= 1).

- clk_i  input  1  clock; all logic on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- start_i  input  1  conversion request; sampled only in IDLE.
- comp_i  input  1  latched comparator output, synchronous to clk_i; 1 = Vin >= Vdac.
- sample_o  output  1  track/hold switch; 1 = track.
- dac_code_o  output  Width  current DAC trial code.
- busy_o  output  1  high from the first SAMPLE cycle through the DONE cycle.
- eosar_o  output  1  one-cycle end-of-conversion pulse.
- data_o  output  Width  last completed result, held until the next completion.

## Operation
- States:
  - IDLE: `start_i`=1 -> SAMPLE. Load code register with MSB-only (1<<(Width-1)). Load cycle counter with SampleCycles-1.
  - SAMPLE: `sample_o`=1. Counter decrements each cycle. At 0 -> SETTLE, counter loaded with SettleCycles-1.
  - SETTLE: DAC settles. Counter decrements. At 0 -> DECIDE.
  - DECIDE: one cycle; the only state that samples `comp_i`. With one-hot trial mask m:
    - code_next = (comp_i ? code : code & ~m) | (m >> 1).
    - If m is the LSB: `data_o` <= code_next, -> DONE.
    - Otherwise: m <= m>>1, counter reload SettleCycles-1, -> SETTLE.
  - DONE: `eosar_o`=1 for exactly this cycle; `dac_code_o` shows the final result. -> IDLE, code register cleared to 0.
- `start_i` is ignored in every state except IDLE, including DONE. No queuing.
- `comp_i` is don't-care outside DECIDE.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - mask, counter and code are 0.
- Reset asserted mid-conversion aborts immediately: no `eosar_o`, `data_o` becomes 0. The next start after reset release behaves normally.
- `data_o` changes only on the DECIDE->DONE edge. A conversion in progress leaves the previous result visible.

## Timing
- `start_i` is sampled high at edge 0. Cycles are counted after that edge.
  - SAMPLE: cycles 1..SampleCycles.
  - Bit k (k=0 is the MSB) occupies SettleCycles+1 cycles; DECIDE is the last of them.
  - DONE / `eosar_o`: cycle SampleCycles + Width*(SettleCycles+1) + 1. This is cycle 29 for the defaults.
  - IDLE: the following cycle. The earliest accepted restart is an edge at the end of that IDLE cycle.
- `busy_o` = (state != IDLE), registered-state decode, glitch-free.
- All outputs are decoded from registers only. There is no combinational path from `start_i` or `comp_i` to any output.
- Cycle counter width: clog2(max(SampleCycles, SettleCycles)).

## Structure
- Shared package / include: state encodings (IDLE, SAMPLE, SETTLE, DECIDE, DONE, 3-bit), shared with the sequencer's debug/status mux.
- Single module. Counter, mask shift register and code register are inline. No sub-module is warranted.

## Test plan
All scenarios use defaults (Width=8, SampleCycles=4, SettleCycles=2) and comparator model comp_i = (vin >= dac_code_o).
- Reset: hold `rst_ni`=0 with `start_i`=1 -> all outputs 0, no state change.
- vin=0xA5, start pulse -> `sample_o` high cycles 1-4, `eosar_o` at cycle 29, `data_o`=0xA5.
  - Trial codes: 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
- Edge values: vin=0x00 -> 0x00; vin=0xFF -> 0xFF, both with `eosar_o` at cycle 29.
- `start_i` held high continuously -> conversions every 30 cycles, exactly one `eosar_o` each. `data_o` retains the previous result until each DONE.
- `comp_i` toggled randomly outside DECIDE, vin=0x3C -> `data_o`=0x3C.
- `rst_ni` pulsed low during bit-3 SETTLE -> outputs 0 within the reset cycle, no `eosar_o`. Next start with vin=0x5A -> 0x5A at cycle 29.

Source files
------------

// File: rtl/sar_adc_ctrl_pkg.sv
// Shared definitions for the SAR ADC controller: 3-bit state encodings also
// consumed by the sequencer's debug/status mux, plus a counter sizing helper.
package sar_adc_ctrl_pkg;

  typedef logic [2:0] sar_state_t;

  localparam sar_state_t ST_IDLE   = 3'd0;
  localparam sar_state_t ST_SAMPLE = 3'd1;
  localparam sar_state_t ST_SETTLE = 3'd2;
  localparam sar_state_t ST_DECIDE = 3'd3;
  localparam sar_state_t ST_DONE   = 3'd4;

  // clog2(max(a, b)), never narrower than one bit
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sar_adc_ctrl_if.sv
// Handshake/analog-control bundle between the measurement sequencer (master)
// and the SAR controller (slave).
interface sar_adc_ctrl_if #(
  parameter int Width = 8
);

  logic             start_i;
  logic             comp_i;
  logic             sample_o;
  logic [Width-1:0] dac_code_o;
  logic             busy_o;
  logic             eosar_o;
  logic [Width-1:0] data_o;

  modport master (
    output start_i,
    output comp_i,
    input  sample_o,
    input  dac_code_o,
    input  busy_o,
    input  eosar_o,
    input  data_o
  );

  modport slave (
    input  start_i,
    input  comp_i,
    output sample_o,
    output dac_code_o,
    output busy_o,
    output eosar_o,
    output data_o
  );

endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: sample, then one settle+decide trial per
// bit from MSB to LSB; result latched on the final decision with a DONE pulse.
module sar_adc_ctrl
  import sar_adc_ctrl_pkg::*;
#(
  parameter int Width        = 8,
  parameter int SampleCycles = 4,
  parameter int SettleCycles = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  sar_adc_ctrl_if.slave    bus
);

  localparam int CntW = cnt_width(SampleCycles, SettleCycles);

  localparam logic [CntW-1:0]  SampleLoad = CntW'(SampleCycles - 1);
  localparam logic [CntW-1:0]  SettleLoad = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0]  CntOne     = CntW'(1);
  localparam logic [Width-1:0] MsbOnly    = {1'b1, {(Width-1){1'b0}}};

  sar_state_t       state_q, state_d;
  logic [CntW-1:0]  cnt_q,   cnt_d;
  logic [Width-1:0] mask_q,  mask_d;
  logic [Width-1:0] code_q,  code_d;
  logic [Width-1:0] data_q,  data_d;

  // next-state, counter, trial mask and code register
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    code_d  = code_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_d = ST_SAMPLE;
          code_d  = MsbOnly;
          mask_d  = MsbOnly;
          cnt_d   = SampleLoad;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SAMPLE: begin
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = SettleLoad;
        end else begin
          cnt_d   = cnt_q - CntOne;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_DECIDE;
        end else begin
          cnt_d   = cnt_q - CntOne;
        end
      end
      ST_DECIDE: begin
        // keep or drop the bit under trial, then raise the next one
        code_d = (bus.comp_i ? code_q : (code_q & ~mask_q)) | (mask_q >> 1);
        if (mask_q[0]) begin
          data_d  = code_d;
          state_d = ST_DONE;
        end else begin
          mask_d  = mask_q >> 1;
          cnt_d   = SettleLoad;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        code_d  = '0;
        mask_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        code_d  = '0;
        mask_d  = '0;
      end
    endcase
  end

  // state registers; reset aborts any conversion and clears the result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      code_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      code_q  <= code_d;
      data_q  <= data_d;
    end
  end

  assign bus.sample_o   = (state_q == ST_SAMPLE);
  assign bus.busy_o     = (state_q != ST_IDLE);
  assign bus.eosar_o    = (state_q == ST_DONE);
  assign bus.dac_code_o = code_q;
  assign bus.data_o     = data_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed + randomized bench for sar_adc_ctrl; expected trial codes come from
// an integer binary-search model of an ideal comparator.
module tb_sar_adc_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [7:0] prev_data;

  sar_adc_ctrl_if #(.Width(8)) bus ();

  sar_adc_ctrl #(
    .Width        (8),
    .SampleCycles (4),
    .SettleCycles (2)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " sample"}, 32'(bus.sample_o),   32'd0);
    check({tag, " busy"},   32'(bus.busy_o),     32'd0);
    check({tag, " eosar"},  32'(bus.eosar_o),    32'd0);
    check({tag, " dac"},    32'(bus.dac_code_o), 32'd0);
    check({tag, " data"},   32'(bus.data_o),     32'd0);
  endtask

  // start_i must already be high before the next rising edge (edge 0);
  // returns at the falling edge inside the IDLE cycle after DONE (cycle 30)
  task automatic conv(input logic [7:0] vin, input bit rnd, input bit hold);
    logic [7:0] trials [8];
    logic [7:0] exp_dac;
    int         code;
    int         t;
    bit         decide;
    string      tg;
    code = 0;
    for (int k = 0; k < 8; k++) begin
      t = code | (1 << (7 - k));
      trials[k] = 8'(t);
      if (int'(vin) >= t) code = t;
    end
    @(posedge clk);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) bus.start_i = 1'b0;
      if (c <= 4)       exp_dac = trials[0];
      else if (c <= 28) exp_dac = trials[(c - 5) / 3];
      else if (c == 29) exp_dac = 8'(code);
      else              exp_dac = 8'h00;
      tg = $sformatf("vin=%02h c%0d", vin, c);
      check({tg, " sample"}, 32'(bus.sample_o),   32'(c <= 4));
      check({tg, " busy"},   32'(bus.busy_o),     32'(c <= 29));
      check({tg, " eosar"},  32'(bus.eosar_o),    32'(c == 29));
      check({tg, " dac"},    32'(bus.dac_code_o), 32'(exp_dac));
      check({tg, " data"},   32'(bus.data_o),     32'((c >= 29) ? vin : prev_data));
      decide = (c >= 7) && (c <= 28) && ((c - 7) % 3 == 0);
      if (rnd && !decide) bus.comp_i = 1'($urandom_range(0, 1));
      else                bus.comp_i = (vin >= bus.dac_code_o);
    end
    prev_data = vin;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    prev_data = 8'h00;
    rst_n        = 1'b0;
    bus.start_i  = 1'b1;
    bus.comp_i   = 1'b0;

    // reset held with start asserted: nothing moves
    repeat (3) begin
      @(negedge clk);
      check_all_zero("reset");
    end
    rst_n       = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    check_all_zero("post-reset idle");

    bus.start_i = 1'b1;
    conv(8'hA5, 1'b0, 1'b0);
    bus.start_i = 1'b1;
    conv(8'h00, 1'b0, 1'b0);
    bus.start_i = 1'b1;
    conv(8'hFF, 1'b0, 1'b0);

    // start held continuously: back-to-back conversions every 30 cycles
    bus.start_i = 1'b1;
    conv(8'($urandom), 1'b0, 1'b1);
    conv(8'($urandom), 1'b0, 1'b1);
    conv(8'($urandom), 1'b0, 1'b0);

    // comparator noise outside the decision cycles
    bus.start_i = 1'b1;
    conv(8'h3C, 1'b1, 1'b0);
    bus.start_i = 1'b1;
    conv(8'($urandom), 1'b1, 1'b0);
    bus.start_i = 1'b1;
    conv(8'h3C, 1'b1, 1'b0);

    // reset during the SETTLE phase of bit 3 (cycle 14)
    bus.start_i = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) bus.start_i = 1'b0;
      bus.comp_i = (8'h77 >= bus.dac_code_o);
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("abort async");
    @(posedge clk);
    #1;
    check_all_zero("abort held");
    @(negedge clk);
    rst_n     = 1'b1;
    prev_data = 8'h00;
    repeat (5) begin
      @(negedge clk);
      check_all_zero("abort quiet");
    end

    bus.start_i = 1'b1;
    conv(8'h5A, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
